// File: rtl/fc_mac_seq.sv
// Fully-connected layer sequencer: walks M output neurons x N input terms,
// fetching one input/weight pair per term, issuing it to a shared mac_fc unit
// and feeding the saturated partial sum back as the next data_c.
module fc_mac_seq #(
    parameter int A_BITWIDTH   = 8,
    parameter int OUT_BITWIDTH = 16,
    parameter int IN_ADDR_W    = 6,
    parameter int OUT_ADDR_W   = 4
) (
    input  logic                             clk,
    input  logic                             rstn,
    input  logic                             start,
    input  logic [IN_ADDR_W-1:0]             cfg_in_last,
    input  logic [OUT_ADDR_W-1:0]            cfg_out_last,
    output logic                             busy,
    output logic                             done,
    output logic                             in_rd_en,
    output logic [IN_ADDR_W-1:0]             in_addr,
    input  logic [A_BITWIDTH-1:0]            in_data,
    output logic                             w_rd_en,
    output logic [OUT_ADDR_W+IN_ADDR_W-1:0]  w_addr,
    input  logic [A_BITWIDTH-1:0]            w_data,
    output logic                             mac_en,
    output logic [A_BITWIDTH-1:0]            mac_a,
    output logic [A_BITWIDTH-1:0]            mac_b,
    output logic [OUT_BITWIDTH-2:0]          mac_c,
    input  logic                             mac_done,
    input  logic [OUT_BITWIDTH-1:0]          mac_mout,
    output logic                             out_valid,
    output logic [OUT_ADDR_W-1:0]            out_addr,
    output logic [OUT_BITWIDTH-1:0]          out_data
);

    localparam int C_BITWIDTH = OUT_BITWIDTH - 1;
    localparam int SAT_MAX_I  = (1 << (C_BITWIDTH - 1)) - 1;
    localparam int SAT_MIN_I  = -(1 << (C_BITWIDTH - 1));
    localparam logic signed [OUT_BITWIDTH-1:0] SAT_MAX = OUT_BITWIDTH'(SAT_MAX_I);
    localparam logic signed [OUT_BITWIDTH-1:0] SAT_MIN = OUT_BITWIDTH'(SAT_MIN_I);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        LATCH,
        ISSUE,
        WAIT,
        DONE
    } state_t;

    state_t                  state;
    logic [IN_ADDR_W-1:0]    k;
    logic [OUT_ADDR_W-1:0]   j;
    logic [IN_ADDR_W-1:0]    n_last;
    logic [OUT_ADDR_W-1:0]   m_last;
    logic [C_BITWIDTH-1:0]   acc;
    logic [IN_ADDR_W-1:0]    k_inc;
    logic [OUT_ADDR_W-1:0]   j_inc;

    // Clamp the full-width MAC result into the narrower signed partial-sum range.
    function automatic logic [C_BITWIDTH-1:0] sat(input logic signed [OUT_BITWIDTH-1:0] v);
        logic signed [OUT_BITWIDTH-1:0] r;
        r = v;
        if (v > SAT_MAX) begin
            r = SAT_MAX;
        end else if (v < SAT_MIN) begin
            r = SAT_MIN;
        end
        return r[C_BITWIDTH-1:0];
    endfunction

    assign k_inc = k + 1'b1;
    assign j_inc = j + 1'b1;

    // Sequencer FSM; every output is registered and set on the edge entering the
    // state it belongs to. The last output write happens in DONE, and the done
    // pulse (with busy dropping) follows one cycle later so the two never overlap.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= IDLE;
            k         <= '0;
            j         <= '0;
            n_last    <= '0;
            m_last    <= '0;
            acc       <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            in_rd_en  <= 1'b0;
            in_addr   <= '0;
            w_rd_en   <= 1'b0;
            w_addr    <= '0;
            mac_en    <= 1'b0;
            mac_a     <= '0;
            mac_b     <= '0;
            mac_c     <= '0;
            out_valid <= 1'b0;
            out_addr  <= '0;
            out_data  <= '0;
        end else begin
            in_rd_en  <= 1'b0;
            w_rd_en   <= 1'b0;
            mac_en    <= 1'b0;
            out_valid <= 1'b0;
            done      <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        n_last   <= cfg_in_last;
                        m_last   <= cfg_out_last;
                        j        <= '0;
                        k        <= '0;
                        acc      <= '0;
                        busy     <= 1'b1;
                        in_rd_en <= 1'b1;
                        w_rd_en  <= 1'b1;
                        in_addr  <= '0;
                        w_addr   <= '0;
                        state    <= FETCH;
                    end
                end
                FETCH: begin
                    state <= LATCH;
                end
                LATCH: begin
                    mac_a  <= in_data;
                    mac_b  <= w_data;
                    mac_c  <= acc;
                    mac_en <= 1'b1;
                    state  <= ISSUE;
                end
                ISSUE: begin
                    state <= WAIT;
                end
                WAIT: begin
                    if (mac_done) begin
                        if (k != n_last) begin
                            acc      <= sat(mac_mout);
                            k        <= k_inc;
                            in_rd_en <= 1'b1;
                            w_rd_en  <= 1'b1;
                            in_addr  <= k_inc;
                            w_addr   <= {j, k_inc};
                            state    <= FETCH;
                        end else begin
                            out_valid <= 1'b1;
                            out_data  <= mac_mout;
                            out_addr  <= j;
                            acc       <= '0;
                            k         <= '0;
                            if (j != m_last) begin
                                j        <= j_inc;
                                in_rd_en <= 1'b1;
                                w_rd_en  <= 1'b1;
                                in_addr  <= '0;
                                w_addr   <= {j_inc, {IN_ADDR_W{1'b0}}};
                                state    <= FETCH;
                            end else begin
                                state <= DONE;
                            end
                        end
                    end
                end
                DONE: begin
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fc_mac_seq.sv
// Bench for fc_mac_seq: models the input/weight SRAMs and a 4-cycle mac_fc,
// queues hand-computed fetch addresses, partial sums and outputs per layer,
// and a monitor pops and compares them whenever the sequencer presents them.
module tb_fc_mac_seq;

    logic        clk;
    logic        rstn;
    logic        start;
    logic [5:0]  cfg_in_last;
    logic [3:0]  cfg_out_last;
    logic        busy;
    logic        done;
    logic        in_rd_en;
    logic [5:0]  in_addr;
    logic [7:0]  in_data;
    logic        w_rd_en;
    logic [9:0]  w_addr;
    logic [7:0]  w_data;
    logic        mac_en;
    logic [7:0]  mac_a;
    logic [7:0]  mac_b;
    logic [14:0] mac_c;
    logic        mac_done;
    logic [15:0] mac_mout;
    logic        out_valid;
    logic [3:0]  out_addr;
    logic [15:0] out_data;

    int tests_run;
    int tests_failed;
    int inv_err;

    logic [7:0]  in_mem [0:63];
    logic [7:0]  w_mem  [0:1023];

    logic [9:0]  q_fetch [$];
    logic [14:0] q_macc  [$];
    logic [3:0]  q_oaddr [$];
    logic [15:0] q_odata [$];

    logic [9:0]  e_fetch;
    logic [14:0] e_macc;
    logic [3:0]  e_oaddr;
    logic [15:0] e_odata;

    logic        hold;
    logic [7:0]  h_a;
    logic [7:0]  h_b;
    logic [14:0] h_c;

    int          mac_cnt;
    logic [15:0] mac_res;

    fc_mac_seq dut (
        .clk          (clk),
        .rstn         (rstn),
        .start        (start),
        .cfg_in_last  (cfg_in_last),
        .cfg_out_last (cfg_out_last),
        .busy         (busy),
        .done         (done),
        .in_rd_en     (in_rd_en),
        .in_addr      (in_addr),
        .in_data      (in_data),
        .w_rd_en      (w_rd_en),
        .w_addr       (w_addr),
        .w_data       (w_data),
        .mac_en       (mac_en),
        .mac_a        (mac_a),
        .mac_b        (mac_b),
        .mac_c        (mac_c),
        .mac_done     (mac_done),
        .mac_mout     (mac_mout),
        .out_valid    (out_valid),
        .out_addr     (out_addr),
        .out_data     (out_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous-read SRAMs: data appears the cycle after the read strobe.
    always @(posedge clk) begin
        if (in_rd_en) in_data <= in_mem[in_addr];
        if (w_rd_en)  w_data  <= w_mem[w_addr];
    end

    // mac_fc model: result = a*b + c, done pulses 4 cycles after mac_en is sampled.
    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            mac_cnt  <= 0;
            mac_done <= 1'b0;
            mac_mout <= '0;
            mac_res  <= '0;
        end else begin
            mac_done <= 1'b0;
            if (mac_en) begin
                mac_res <= 16'(int'($signed(mac_a)) * int'($signed(mac_b)) + int'($signed(mac_c)));
                mac_cnt <= 4;
            end else if (mac_cnt > 0) begin
                mac_cnt <= mac_cnt - 1;
                if (mac_cnt == 1) begin
                    mac_done <= 1'b1;
                    mac_mout <= mac_res;
                end
            end
        end
    end

    // Scoreboard monitor plus protocol invariants, sampled on the falling edge.
    always @(negedge clk) begin
        if (!rstn) begin
            hold = 1'b0;
        end else begin
            if (in_rd_en) begin
                tests_run++;
                if (q_fetch.size() == 0) begin
                    tests_failed++;
                    $display("[TB] FAIL fetch: unexpected read w_addr=%h", w_addr);
                end else begin
                    e_fetch = q_fetch.pop_front();
                    if (w_addr !== e_fetch || in_addr !== e_fetch[5:0] || w_rd_en !== 1'b1) begin
                        tests_failed++;
                        $display("[TB] FAIL fetch: got w_addr=%h in_addr=%h w_rd_en=%b, expected w_addr=%h in_addr=%h w_rd_en=1",
                                 w_addr, in_addr, w_rd_en, e_fetch, e_fetch[5:0]);
                    end
                end
            end
            if (mac_en) begin
                tests_run++;
                if (q_macc.size() == 0) begin
                    tests_failed++;
                    $display("[TB] FAIL mac_c: unexpected issue mac_c=%0d", $signed(mac_c));
                end else begin
                    e_macc = q_macc.pop_front();
                    if (mac_c !== e_macc) begin
                        tests_failed++;
                        $display("[TB] FAIL mac_c: got %0d, expected %0d", $signed(mac_c), $signed(e_macc));
                    end
                end
            end
            if (out_valid) begin
                tests_run++;
                if (q_odata.size() == 0) begin
                    tests_failed++;
                    $display("[TB] FAIL output: unexpected write addr=%0d data=%h", out_addr, out_data);
                end else begin
                    e_oaddr = q_oaddr.pop_front();
                    e_odata = q_odata.pop_front();
                    if (out_addr !== e_oaddr || out_data !== e_odata) begin
                        tests_failed++;
                        $display("[TB] FAIL output: got addr=%0d data=%h, expected addr=%0d data=%h",
                                 out_addr, out_data, e_oaddr, e_odata);
                    end
                end
            end
            if (done && busy) inv_err++;
            if (mac_en && mac_done) inv_err++;
            if (mac_en) begin
                hold = 1'b1;
                h_a  = mac_a;
                h_b  = mac_b;
                h_c  = mac_c;
            end else if (hold) begin
                if (mac_a !== h_a || mac_b !== h_b || mac_c !== h_c) inv_err++;
                if (mac_done) hold = 1'b0;
            end
        end
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog");
    end

    // Queue the fetch address and partial sum expected for term (j,k).
    task automatic expectTerm(input int j, input int k, input int macc);
        q_fetch.push_back(10'(j * 64 + k));
        q_macc.push_back(15'(macc));
    endtask

    // Queue one expected output-buffer write.
    task automatic expectOut(input int addr, input int data);
        q_oaddr.push_back(4'(addr));
        q_odata.push_back(16'(data));
    endtask

    // Pulse start, optionally inject a second start mid-layer, then wait for done.
    task automatic applyStimulus(input int n_last, input int m_last, input bit inject);
        bit seen;
        @(negedge clk);
        start        = 1'b1;
        cfg_in_last  = 6'(n_last);
        cfg_out_last = 4'(m_last);
        @(negedge clk);
        start = 1'b0;
        tests_run++;
        if (busy !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL busy after start: got %b, expected 1", busy);
        end
        seen = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            if (inject && c == 8) begin
                start        = 1'b1;
                cfg_in_last  = '0;
                cfg_out_last = '0;
            end else begin
                start = 1'b0;
            end
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
        start = 1'b0;
        tests_run++;
        if (!seen) begin
            tests_failed++;
            $display("[TB] FAIL done: got no done pulse, expected one within 3000 cycles");
        end else begin
            tests_run++;
            if (busy !== 1'b0) begin
                tests_failed++;
                $display("[TB] FAIL busy at done: got %b, expected 0", busy);
            end
        end
    endtask

    // Every queued expectation must have been consumed by the monitor.
    task automatic checkOutput(input string name);
        tests_run++;
        if (q_fetch.size() != 0 || q_macc.size() != 0 || q_odata.size() != 0) begin
            tests_failed++;
            $display("[TB] FAIL %s: pending fetch=%0d macc=%0d out=%0d, expected 0 0 0",
                     name, q_fetch.size(), q_macc.size(), q_odata.size());
        end
        q_fetch.delete();
        q_macc.delete();
        q_oaddr.delete();
        q_odata.delete();
    endtask

    // All DUT outputs must read zero.
    task automatic checkZero(input string name);
        logic [72:0] v;
        v = {busy, done, in_rd_en, in_addr, w_rd_en, w_addr, mac_en, mac_a, mac_b,
             mac_c, out_valid, out_addr, out_data};
        tests_run++;
        if (v !== '0) begin
            tests_failed++;
            $display("[TB] FAIL %s: got outputs %h, expected all zero", name, v);
        end
    endtask

    // Load the N=4 vectors x={1,2,3,4}, w={5,6,7,8} for neuron 0.
    task automatic loadT2();
        for (int i = 0; i < 4; i++) begin
            in_mem[i] = 8'(i + 1);
            w_mem[i]  = 8'(i + 5);
        end
    endtask

    initial begin
        int nmac;
        tests_run    = 0;
        tests_failed = 0;
        inv_err      = 0;
        hold         = 1'b0;
        rstn         = 1'b0;
        start        = 1'b0;
        cfg_in_last  = '0;
        cfg_out_last = '0;
        for (int i = 0; i < 64; i++)   in_mem[i] = '0;
        for (int i = 0; i < 1024; i++) w_mem[i]  = '0;

        repeat (3) @(posedge clk);
        #1 checkZero("reset state");
        @(negedge clk);
        rstn = 1'b1;

        // T1: single term 3*4
        in_mem[0] = 8'd3;
        w_mem[0]  = 8'd4;
        expectTerm(0, 0, 0);
        expectOut(0, 12);
        applyStimulus(0, 0, 1'b0);
        checkOutput("T1");

        // T2: 1*5+2*6+3*7+4*8
        loadT2();
        expectTerm(0, 0, 0);
        expectTerm(0, 1, 5);
        expectTerm(0, 2, 17);
        expectTerm(0, 3, 38);
        expectOut(0, 70);
        applyStimulus(3, 0, 1'b0);
        checkOutput("T2");

        // T3: partial sum saturates at 16383, final term unsaturated
        for (int i = 0; i < 4; i++) begin
            in_mem[i] = 8'd127;
            w_mem[i]  = 8'd127;
        end
        expectTerm(0, 0, 0);
        expectTerm(0, 1, 16129);
        expectTerm(0, 2, 16383);
        expectTerm(0, 3, 16383);
        expectOut(0, 32512);
        applyStimulus(3, 0, 1'b0);
        checkOutput("T3");

        // T4: N=2, M=3 address walk, with a stray start mid-layer
        in_mem[0]  = 8'd2;
        in_mem[1]  = 8'd3;
        w_mem[0]   = 8'd1;
        w_mem[1]   = 8'd1;
        w_mem[64]  = 8'd2;
        w_mem[65]  = 8'd2;
        w_mem[128] = 8'hFF;
        w_mem[129] = 8'd4;
        expectTerm(0, 0, 0);
        expectTerm(0, 1, 2);
        expectTerm(1, 0, 0);
        expectTerm(1, 1, 4);
        expectTerm(2, 0, 0);
        expectTerm(2, 1, -2);
        expectOut(0, 5);
        expectOut(1, 10);
        expectOut(2, 10);
        applyStimulus(1, 2, 1'b1);
        checkOutput("T4");

        // T5: signed terms -3*4 + 5*-2 = -22
        in_mem[0] = 8'hFD;
        in_mem[1] = 8'd5;
        w_mem[0]  = 8'd4;
        w_mem[1]  = 8'hFE;
        expectTerm(0, 0, 0);
        expectTerm(0, 1, -12);
        expectOut(0, 16'hFFEA);
        applyStimulus(1, 0, 1'b0);
        checkOutput("T5");

        // T6: reset during the wait of term 2, then a clean rerun
        loadT2();
        expectTerm(0, 0, 0);
        expectTerm(0, 1, 5);
        @(negedge clk);
        start        = 1'b1;
        cfg_in_last  = 6'd3;
        cfg_out_last = 4'd0;
        @(negedge clk);
        start = 1'b0;
        nmac  = 0;
        for (int c = 0; c < 200; c++) begin
            if (mac_en) nmac++;
            if (nmac == 2) break;
            @(negedge clk);
        end
        tests_run++;
        if (nmac != 2) begin
            tests_failed++;
            $display("[TB] FAIL T6 second issue: got %0d issues, expected 2", nmac);
        end
        repeat (2) @(negedge clk);
        #2 rstn = 1'b0;
        #1 checkZero("T6 async reset");
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        checkOutput("T6 abort");
        expectTerm(0, 0, 0);
        expectTerm(0, 1, 5);
        expectTerm(0, 2, 17);
        expectTerm(0, 3, 38);
        expectOut(0, 70);
        applyStimulus(3, 0, 1'b0);
        checkOutput("T6 rerun");

        tests_run++;
        if (inv_err != 0) begin
            tests_failed++;
            $display("[TB] FAIL invariants: got %0d violations, expected 0", inv_err);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
